branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, giving 2^INDEX_BITS direct-mapped predictor entries.
REQ-002 SHALL have parameter WIDTH, default 32, the PC and target width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 PCF  in  WIDTH  fetch-stage PC used for lookup.
REQ-006 PredictTakenF  out  1  fetch-stage prediction: branch taken.
REQ-007 PredictTargetF  out  WIDTH  predicted target, valid when PredictTakenF=1.
REQ-008 BranchE  in  1  execute stage holds a resolved conditional branch or jump.
REQ-009 TakenE  in  1  actual branch outcome.
REQ-010 PCE  in  WIDTH  PC of the execute-stage branch.
REQ-011 TargetE  in  WIDTH  actual computed target.
REQ-012 PredTakenE, PredTargetE  in  1, WIDTH  prediction carried down the pipe with the branch.
REQ-013 flushBranch  out  1  mispredict; consumed by the hazard unit to flush the front-end.
REQ-014 RecoverPCE  out  WIDTH  correct next PC on mispredict.
REQ-015 BranchCount, MispredictCount  out  32 each  performance counters (see Configuration).

Function
REQ-016 Each entry SHALL hold: valid bit, tag = PC[WIDTH-1:INDEX_BITS+2], target (WIDTH), 2-bit saturating counter.
REQ-017 Index SHALL be PC[INDEX_BITS+1:2]; PC[1:0] ignored.
REQ-018 Lookup SHALL be combinational: hit = valid && tag match; PredictTakenF = hit && counter[1]; PredictTargetF = entry target when hit, else 0.
REQ-019 flushBranch SHALL be combinational: BranchE && ((TakenE != PredTakenE) || (TakenE && PredTargetE != TargetE)).
REQ-020 RecoverPCE SHALL be TargetE when TakenE=1, else PCE+4 (modulo 2^WIDTH); value don't-care when flushBranch=0.
REQ-021 On a clock edge with BranchE=1, the entry at PCE's index SHALL update; no update when BranchE=0.
REQ-022 Counter update: TakenE=1 increments, saturating at 2'b11; TakenE=0 decrements, saturating at 2'b00.
REQ-023 Update with tag miss and TakenE=1 SHALL allocate: valid=1, tag/target written, counter=2'b10.
REQ-024 Update with tag miss and TakenE=0 SHALL leave the entry unchanged (no allocation).
REQ-025 Update with tag hit and TakenE=1 SHALL also overwrite the target with TargetE.
REQ-026 Same-cycle lookup and update to the same index: lookup SHALL return pre-update contents (no bypass).
REQ-027 Update SHALL proceed regardless of flushBranch; the branch in E is architecturally committed.

Reset
REQ-028 rst_n=0 SHALL immediately clear all valid bits and set all counters to 2'b01, without waiting for a clock edge.
REQ-029 rst_n=0 SHALL zero BranchCount and MispredictCount.
REQ-030 During reset: PredictTakenF=0 and PredictTargetF=0; flushBranch and RecoverPCE follow REQ-019/020 combinationally.
REQ-031 An update coincident with reset assertion SHALL be discarded.

Configuration
REQ-032 Macro BP_PERF_CNT_EN defined: BranchCount SHALL increment on each edge with BranchE=1; MispredictCount SHALL increment on each edge with flushBranch=1; both saturate at 32'hFFFFFFFF.
REQ-033 Macro BP_PERF_CNT_EN undefined: both counters SHALL tie to 0 and no counter flops SHALL be inferred; all other behaviour is identical.

Verification
REQ-034 Reset, then PCF=0x100 -> PredictTakenF=0, PredictTargetF=0.
REQ-035 BranchE=1, PCE=0x100, TakenE=1, TargetE=0x80, PredTakenE=0 -> flushBranch=1, RecoverPCE=0x80; next cycle PCF=0x100 -> PredictTakenF=1, PredictTargetF=0x80.
REQ-036 Four updates at PCE=0x100 with TakenE=1, then three with TakenE=0 -> counter sequence 10,11,11,11,10,01,00; PredictTakenF=0 after the 6th update.
REQ-037 Entry at 0x100 is valid; update PCE=0x140 (same index, INDEX_BITS=4) with TakenE=1 -> PCF=0x100 misses, PredictTakenF=0.
REQ-038 BranchE=1, TakenE=1, PredTakenE=1, PredTargetE=0x200, TargetE=0x204 -> flushBranch=1, RecoverPCE=0x204; TakenE=0, PredTakenE=0, PCE=0x300 -> flushBranch=0, RecoverPCE=0x304.
REQ-039 With BP_PERF_CNT_EN: 5 branch updates with 2 mispredicts, then rst_n=0 mid-cycle -> counts 5/2 before reset, 0/0 immediately after reset asserts.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit counters plus target buffer.
// Optional performance counters are enabled by defining BP_PERF_CNT_EN.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] PCF,
    output logic             PredictTakenF,
    output logic [WIDTH-1:0] PredictTargetF,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] TargetE,
    input  logic             PredTakenE,
    input  logic [WIDTH-1:0] PredTargetE,
    output logic             flushBranch,
    output logic [WIDTH-1:0] RecoverPCE,
    output logic [31:0]      BranchCount,
    output logic [31:0]      MispredictCount
);
    localparam int N  = 1 << INDEX_BITS;
    localparam int TW = WIDTH - INDEX_BITS - 2;

    logic             valid [N];
    logic [TW-1:0]    tags  [N];
    logic [WIDTH-1:0] tgts  [N];
    logic [1:0]       ctrs  [N];

    logic [INDEX_BITS-1:0] fidx, eidx;
    logic [TW-1:0]         ftag, etag;
    logic                  hitf, hite;
    logic [1:0]            ctr_nxt;

    assign fidx = PCF[INDEX_BITS+1:2];
    assign ftag = PCF[WIDTH-1:INDEX_BITS+2];
    assign eidx = PCE[INDEX_BITS+1:2];
    assign etag = PCE[WIDTH-1:INDEX_BITS+2];

    assign hitf = valid[fidx] && (tags[fidx] == ftag);
    assign hite = valid[eidx] && (tags[eidx] == etag);

    assign PredictTakenF  = hitf && ctrs[fidx][1];
    assign PredictTargetF = hitf ? tgts[fidx] : '0;

    assign flushBranch = BranchE && ((TakenE != PredTakenE) ||
                         (TakenE && (PredTargetE != TargetE)));
    assign RecoverPCE  = TakenE ? TargetE : PCE + WIDTH'(4);

    always_comb begin
        ctr_nxt = ctrs[eidx];
        if (TakenE && ctrs[eidx] != 2'b11)
            ctr_nxt = ctrs[eidx] + 2'b01;
        else if (!TakenE && ctrs[eidx] != 2'b00)
            ctr_nxt = ctrs[eidx] - 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                valid[i] <= 1'b0;
                tags[i]  <= '0;
                tgts[i]  <= '0;
                ctrs[i]  <= 2'b01;
            end
        end else if (BranchE) begin
            if (hite) begin
                ctrs[eidx] <= ctr_nxt;
                if (TakenE)
                    tgts[eidx] <= TargetE;
            end else if (TakenE) begin
                // not-taken misses never allocate
                valid[eidx] <= 1'b1;
                tags[eidx]  <= etag;
                tgts[eidx]  <= TargetE;
                ctrs[eidx]  <= 2'b10;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] bcnt, mcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            mcnt <= '0;
        end else begin
            if (BranchE && bcnt != 32'hFFFF_FFFF)
                bcnt <= bcnt + 32'd1;
            if (flushBranch && mcnt != 32'hFFFF_FFFF)
                mcnt <= mcnt + 32'd1;
        end
    end

    assign BranchCount     = bcnt;
    assign MispredictCount = mcnt;
`else
    assign BranchCount     = '0;
    assign MispredictCount = '0;
`endif

endmodule
